// File: rtl/jellyvl_synctimer_core_mc.sv
//------------------------------------------------------------------------------
// Module   : jellyvl_synctimer_core_mc
// Brief    : Multi-channel synchronised timer core. Fractional-period local
//            time with per-channel correction sources, fixed-priority or
//            round-robin arbitration, hard-jump or +/-1 slew correction, and
//            saturated error / drop status.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jellyvl_synctimer_core_mc #(
  parameter int TIMER_WIDTH = 64,
  parameter int NUMERATOR   = 10,
  parameter int DENOMINATOR = 3,
  parameter int CHANNELS    = 4,
  parameter int PHASE_WIDTH = 32,
  parameter int SLEW_WIDTH  = 16,
  parameter int DROP_WIDTH  = 16,
  parameter int ARB_MODE    = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [TIMER_WIDTH-1:0]          set_time,
  input  logic                            set_valid,
  input  logic signed [PHASE_WIDTH-1:0]   param_phase_min,
  input  logic signed [PHASE_WIDTH-1:0]   param_phase_max,
  input  logic [SLEW_WIDTH-1:0]           param_slew_interval,
  input  logic [CHANNELS-1:0]             channel_enable,
  input  logic [CHANNELS*TIMER_WIDTH-1:0] correct_time,
  input  logic [CHANNELS-1:0]             correct_override,
  input  logic [CHANNELS-1:0]             correct_valid,
  output logic [CHANNELS-1:0]             correct_accept,
  output logic [TIMER_WIDTH-1:0]          current_time,
  output logic                            adjusting,
  output logic [PHASE_WIDTH-1:0]          last_error,
  output logic [3:0]                      last_channel,
  output logic [DROP_WIDTH-1:0]           drop_count
);

  // Whole and fractional part of the per-cycle increment.
  localparam logic [TIMER_WIDTH-1:0] INC    = TIMER_WIDTH'(NUMERATOR / DENOMINATOR);
  localparam int                     FRAC_W = $clog2(2 * DENOMINATOR) + 1;
  localparam logic [FRAC_W-1:0]      FRAC   = FRAC_W'(NUMERATOR % DENOMINATOR);
  localparam logic [FRAC_W-1:0]      DEN    = FRAC_W'(DENOMINATOR);
  localparam int                     IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [TIMER_WIDTH-1:0] time_q,  time_d;
  logic [FRAC_W-1:0]      frac_q,  frac_d;
  logic [PHASE_WIDTH-1:0] rem_q,   rem_d;
  logic [SLEW_WIDTH-1:0]  cnt_q,   cnt_d;
  logic [PHASE_WIDTH-1:0] lerr_q,  lerr_d;
  logic [3:0]             lch_q,   lch_d;
  logic [DROP_WIDTH-1:0]  drop_q,  drop_d;
  logic [IDX_W-1:0]       ptr_q,   ptr_d;
  logic                   adj_q,   adj_d;

  logic [CHANNELS-1:0]    cand;
  logic [IDX_W-1:0]       arb_base;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_found;
  logic                   accept_valid;
  logic                   drop_event;

  logic [TIMER_WIDTH-1:0] sel_time;
  logic [TIMER_WIDTH-1:0] diff;
  logic [PHASE_WIDTH-1:0] err_sat;
  logic                   do_jump;

  logic                   step_up;
  logic                   step_dn;
  logic [PHASE_WIDTH-1:0] slew_rem;
  logic [SLEW_WIDTH-1:0]  slew_cnt;

  logic [FRAC_W-1:0]      frac_sum;
  logic                   carry;
  logic [FRAC_W-1:0]      frac_inc;
  logic [TIMER_WIDTH-1:0] delta;

  assign arb_base = (ARB_MODE == 1) ? ptr_q : '0;

  // Arbiter: scan candidates starting at the base index, wrapping around.
  always_comb begin : arb_comb
    int scan;
    cand        = correct_valid & channel_enable;
    grant_idx   = '0;
    grant_found = 1'b0;
    scan        = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      scan = int'(arb_base) + k;
      if (scan >= CHANNELS) scan = scan - CHANNELS;
      if (!grant_found && cand[IDX_W'(scan)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(scan);
      end
    end
  end

  // A load strobe blocks all corrections for the cycle.
  assign accept_valid   = grant_found & ~set_valid;
  assign correct_accept = accept_valid ? (CHANNELS'(1) << grant_idx) : '0;

  // Contention, masking, or a load pre-empting valids all count as drops.
  assign drop_event = set_valid ? (|correct_valid)
                                : (((cand & (cand - 1'b1)) != '0) ||
                                   ((correct_valid & ~channel_enable) != '0));

  // Raw error is taken modulo 2^TIMER_WIDTH, so wrap-around gives the short way.
  assign sel_time = correct_time[grant_idx*TIMER_WIDTH +: TIMER_WIDTH];
  assign diff     = sel_time - time_q;

  generate
    if (TIMER_WIDTH > PHASE_WIDTH) begin : g_sat_wide
      logic [TIMER_WIDTH-PHASE_WIDTH:0] upper;
      assign upper = diff[TIMER_WIDTH-1:PHASE_WIDTH-1];
      // Clamp to the signed phase range when the upper bits are not a sign run.
      always_comb begin
        if (upper == '0 || upper == '1) begin
          err_sat = diff[PHASE_WIDTH-1:0];
        end else if (diff[TIMER_WIDTH-1]) begin
          err_sat = {1'b1, {(PHASE_WIDTH-1){1'b0}}};
        end else begin
          err_sat = {1'b0, {(PHASE_WIDTH-1){1'b1}}};
        end
      end
    end else begin : g_sat_ext
      assign err_sat = PHASE_WIDTH'($signed(diff));
    end
  endgenerate

  assign do_jump = correct_override[grant_idx] ||
                   ($signed(err_sat) > param_phase_max) ||
                   ($signed(err_sat) < param_phase_min);

  // Slew engine: one +/-1 step every (interval+1) cycles while remainder is nonzero.
  always_comb begin
    step_up  = 1'b0;
    step_dn  = 1'b0;
    slew_rem = rem_q;
    slew_cnt = cnt_q;
    if (rem_q != '0) begin
      if (cnt_q == param_slew_interval) begin
        slew_cnt = '0;
        if (rem_q[PHASE_WIDTH-1]) begin
          step_dn  = 1'b1;
          slew_rem = rem_q + 1'b1;
        end else begin
          step_up  = 1'b1;
          slew_rem = rem_q - 1'b1;
        end
      end else begin
        slew_cnt = cnt_q + 1'b1;
      end
    end
  end

  // Next-state selection: load beats jump beats slew; an accept suppresses the step.
  always_comb begin
    frac_sum = frac_q + FRAC;
    carry    = (frac_sum >= DEN);
    frac_inc = carry ? (frac_sum - DEN) : frac_sum;
    delta    = INC + TIMER_WIDTH'(carry);

    time_d = time_q + delta;
    frac_d = frac_inc;
    rem_d  = slew_rem;
    cnt_d  = slew_cnt;
    lerr_d = lerr_q;
    lch_d  = lch_q;
    ptr_d  = ptr_q;

    if (set_valid) begin
      time_d = set_time;
      frac_d = '0;
      rem_d  = '0;
      cnt_d  = '0;
    end else if (accept_valid) begin
      lerr_d = err_sat;
      lch_d  = 4'(grant_idx);
      ptr_d  = (grant_idx == IDX_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
      if (do_jump) begin
        time_d = sel_time;
        frac_d = '0;
        rem_d  = '0;
        cnt_d  = '0;
      end else begin
        rem_d  = err_sat;
        cnt_d  = '0;
      end
    end else if (step_up) begin
      time_d = time_q + delta + 1'b1;
    end else if (step_dn) begin
      time_d = time_q + delta - 1'b1;
    end

    drop_d = (drop_event && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    adj_d  = (rem_d != '0);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      time_q <= '0;
      frac_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      lerr_q <= '0;
      lch_q  <= '0;
      drop_q <= '0;
      ptr_q  <= '0;
      adj_q  <= 1'b0;
    end else begin
      time_q <= time_d;
      frac_q <= frac_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      lerr_q <= lerr_d;
      lch_q  <= lch_d;
      drop_q <= drop_d;
      ptr_q  <= ptr_d;
      adj_q  <= adj_d;
    end
  end

  assign current_time = time_q;
  assign adjusting    = adj_q;
  assign last_error   = lerr_q;
  assign last_channel = lch_q;
  assign drop_count   = drop_q;

endmodule

`default_nettype wire
